spm_host: RTL and testbench

SPM_HOST -- requirements
Module: spm_host

---
 rtl/spm_host_pkg.sv | 23 ++
 rtl/spm_host_if.sv | 27 ++
 rtl/spm_host_shreg.sv | 27 ++
 rtl/spm_host.sv | 130 +++++++++++++
 tb/tb_spm_host.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spm_host_pkg.sv
// Shared definitions for the serial-multiplier host.
//   state_t  : host FSM states
//   SIZE_DEF : default operand width
//   LAT_DEF  : default multiplier latency (my bit driven -> mp bit valid)
//   cnt_w()  : width of the SHIFT-phase counter
package spm_host_pkg;

   localparam int SIZE_DEF = 32;
   localparam int LAT_DEF  = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Counter must hold 0 .. 2*size+lat-1.
   function automatic int cnt_w(input int size, input int lat);
      return $clog2(2*size + lat + 1);
   endfunction

endpackage

// File: rtl/spm_host_if.sv
// Operand/product handshake between a requester and spm_host.
//   in_valid/in_ready : operand pair a, b offered / accepted
//   out_valid/out_ready : product prod offered / taken
// master = requester side, slave = spm_host side.
interface spm_host_if
   import spm_host_pkg::*;
#(
   parameter int SIZE = SIZE_DEF
);
   logic                in_valid;
   logic                in_ready;
   logic [SIZE-1:0]     a;
   logic [SIZE-1:0]     b;
   logic                out_valid;
   logic                out_ready;
   logic [2*SIZE-1:0]   prod;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, prod
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, prod
   );
endinterface

// File: rtl/spm_host_shreg.sv
// Loadable right-shift register (LSB leaves first, shift_in enters at MSB).
//   clk, rst  : clock, async active-low clear
//   load      : parallel load of load_val (wins over shift_en)
//   shift_en  : shift right by one, shift_in -> q[W-1]
//   q         : register contents
module spm_host_shreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         shift_en,
   input  logic         shift_in,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         q <= '0;
      else if (load)
         q <= load_val;
      else if (shift_en)
         q <= {shift_in, q[W-1:1]};
   end

endmodule

// File: rtl/spm_host.sv
// Host controller for a bit-serial signed multiplier.
// Accepts a, b over the host handshake, clears the multiplier for one cycle,
// streams b LSB-first (sign-extended to 2*SIZE bits) on my while holding a on
// mx, collects the 2*SIZE-bit product from mp, then offers it on prod.
//   clk, rst   : clock, async active-low reset
//   host       : slave side of spm_host_if (in/out handshakes, a, b, prod)
//   busy       : high whenever the FSM is not in IDLE
//   mx         : parallel multiplicand to the multiplier
//   my         : serial multiplier bit, LSB first
//   mrst       : active-low clear to the multiplier
//   mp         : serial product bit from the multiplier, LSB first
module spm_host
   import spm_host_pkg::*;
#(
   parameter int SIZE = SIZE_DEF,
   parameter int LAT  = LAT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   spm_host_if.slave        host,
   output logic             busy,
   output logic [SIZE-1:0]  mx,
   output logic             my,
   output logic             mrst,
   input  logic             mp
);

   localparam int CW   = cnt_w(SIZE, LAT);
   localparam int LAST = 2*SIZE + LAT - 1;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic              ready;
   logic              valid;
   logic              my_en;
   logic              accept;
   logic              shift;
   logic              sample;
   logic [SIZE-1:0]   y_q;
   logic [2*SIZE-1:0] p_q;

   assign accept = (state == IDLE) && host.in_valid;
   assign shift  = (state == SHIFT);
   // The first LAT SHIFT cycles carry no product bits yet.
   assign sample = shift && (cnt >= CW'(LAT));

   // y_q shifts arithmetically, so once b is exhausted its bit 0 keeps
   // repeating the sign bit; my_en gates the stream to the first 2*SIZE cycles.
   assign my = my_en & y_q[0];

   assign host.in_ready  = ready;
   assign host.out_valid = valid;
   assign host.prod      = p_q;

   // my serializer: holds b, arithmetic right shift once per SHIFT cycle
   spm_host_shreg #(.W(SIZE)) u_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (host.b),
      .shift_en (shift),
      .shift_in (y_q[SIZE-1]),
      .q        (y_q)
   );

   // mp deserializer: after 2*SIZE samples the first bit has reached bit 0
   spm_host_shreg #(.W(2*SIZE)) u_des (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val ('0),
      .shift_en (sample),
      .shift_in (mp),
      .q        (p_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         mx    <= '0;
         mrst  <= 1'b1;
         busy  <= 1'b0;
         ready <= 1'b1;
         valid <= 1'b0;
         my_en <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (host.in_valid) begin
                  mx    <= host.a;
                  mrst  <= 1'b0;
                  busy  <= 1'b1;
                  ready <= 1'b0;
                  state <= CLEAR;
               end
            end
            CLEAR: begin
               mrst  <= 1'b1;
               cnt   <= '0;
               my_en <= 1'b1;
               state <= SHIFT;
            end
            SHIFT: begin
               if (cnt == CW'(2*SIZE - 1))
                  my_en <= 1'b0;
               if (cnt == CW'(LAST)) begin
                  cnt   <= '0;
                  valid <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               // in_valid is deliberately ignored here; a new pair can only
               // be taken from IDLE on a later edge.
               if (host.out_ready) begin
                  valid <= 1'b0;
                  busy  <= 1'b0;
                  ready <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spm_host.sv
// Bench for spm_host (SIZE=32, LAT=1) with a behavioural serial multiplier.
// Driver issues directed operand pairs and pushes hand-computed products;
// a negedge monitor pops and compares on each product handshake and watches
// latency, mrst pulse, DONE stability and reset values.
module tb_spm_host;

   logic        clk;
   logic        rst;
   logic        busy;
   logic [31:0] mx;
   logic        my;
   logic        mrst;
   logic        mp;

   int total  = 0;
   int passed = 0;
   int cyc    = 0;

   logic [63:0] exp_q[$];

   spm_host_if #(.SIZE(32)) hif ();

   spm_host #(.SIZE(32), .LAT(1)) dut (
      .clk  (clk),
      .rst  (rst),
      .host (hif),
      .busy (busy),
      .mx   (mx),
      .my   (my),
      .mrst (mrst),
      .mp   (mp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural serial multiplier: adds sext(mx)<<k for each my bit k and
   // returns product bit k one cycle later.
   logic [63:0] acc = '0;
   logic [63:0] nxt;
   logic [63:0] sx;
   logic [6:0]  k   = '0;
   initial mp = 1'b0;

   always_comb begin
      sx  = {{32{mx[31]}}, mx};
      nxt = acc;
      if (my && k < 7'd64)
         nxt = acc + (sx << k);
   end

   always @(posedge clk) begin
      if (!mrst) begin
         acc <= '0;
         k   <= '0;
         mp  <= 1'b0;
      end else begin
         acc <= nxt;
         mp  <= (k < 7'd64) ? nxt[k[5:0]] : 1'b0;
         if (k < 7'd127)
            k <= k + 7'd1;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got === want)
         passed++;
      else
         $display("FAIL %s: got %0h want %0h", name, got, want);
   endtask

   // ---------------- monitor ----------------
   int          acc_cyc   = -100;
   bit          lat_pend  = 1'b0;
   bit          prev_ov   = 1'b0;
   bit          prev_hs   = 1'b0;
   logic [63:0] prev_prod = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("rst_mx",        64'(mx), 64'd0);
            chk("rst_my",        64'(my), 64'd0);
            chk("rst_mrst",      64'(mrst), 64'd1);
            chk("rst_prod",      hif.prod, 64'd0);
            chk("rst_out_valid", 64'(hif.out_valid), 64'd0);
            chk("rst_busy",      64'(busy), 64'd0);
            chk("rst_in_ready",  64'(hif.in_ready), 64'd1);
            lat_pend = 1'b0;
            prev_ov  = 1'b0;
            prev_hs  = 1'b0;
            acc_cyc  = -100;
         end else begin
            bit hs;
            if (hif.out_valid && !prev_ov)
               chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (hif.out_valid && lat_pend) begin
               chk("latency", 64'(cyc - acc_cyc), 64'd67);
               lat_pend = 1'b0;
            end
            if (hif.out_valid) begin
               chk("busy_done",     64'(busy), 64'd1);
               chk("in_ready_done", 64'(hif.in_ready), 64'd0);
            end
            if (hif.out_valid && prev_ov && !prev_hs)
               chk("prod_stable", hif.prod, prev_prod);
            if (cyc == acc_cyc + 1) begin
               chk("mrst_low",   64'(mrst), 64'd0);
               chk("busy_clear", 64'(busy), 64'd1);
            end else if (cyc == acc_cyc + 2) begin
               chk("mrst_high", 64'(mrst), 64'd1);
            end else if (!mrst) begin
               chk("mrst_stray", 64'(mrst), 64'd1);
            end
            hs = hif.out_valid && hif.out_ready;
            if (hs) begin
               chk("prod_queued", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0)
                  chk("prod", hif.prod, exp_q.pop_front());
            end
            if (hif.in_valid && hif.in_ready) begin
               acc_cyc  = cyc;
               lat_pend = 1'b1;
            end
            prev_ov   = hif.out_valid;
            prev_hs   = hs;
            prev_prod = hif.prod;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [63:0] e);
      int n = 0;
      @(posedge clk); #1;
      while (!hif.in_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_wait", 64'(hif.in_ready), 64'd1);
      hif.in_valid = 1'b1;
      hif.a        = av;
      hif.b        = bv;
      exp_q.push_back(e);
      @(posedge clk); #1;
      // Operands are scrambled after the accept edge; the DUT must not care.
      hif.in_valid = 1'b0;
      hif.a        = $urandom;
      hif.b        = $urandom;
   endtask

   task automatic wait_out();
      int n = 0;
      while (!hif.out_valid && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("out_valid_wait", 64'(hif.out_valid), 64'd1);
   endtask

   task automatic take(input int stall);
      wait_out();
      repeat (stall) begin
         @(posedge clk); #1;
      end
      hif.out_ready = 1'b1;
      @(posedge clk); #1;
      hif.out_ready = 1'b0;
   endtask

   task automatic run(input logic [31:0] av, input logic [31:0] bv, input logic [63:0] e,
                      input int stall);
      send(av, bv, e);
      take(stall);
   endtask

   initial begin
      rst           = 1'b0;
      hif.in_valid  = 1'b0;
      hif.a         = '0;
      hif.b         = '0;
      hif.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      run(32'd3,         32'd5,         64'd15,                  0);
      run(32'hFFFFFFFF,  32'hFFFFFFFF,  64'd1,                   0);
      run(32'h7FFFFFFF,  32'h80000000,  64'hC0000000_80000000,   2);
      run(32'h80000000,  32'h80000000,  64'h40000000_00000000,   0);
      run(32'hFFFFFFFF,  32'd7,         64'hFFFFFFFF_FFFFFFF9,   0);

      // DONE held for 10 cycles with a new pair already offered
      send(32'hFFFFFF9C, 32'd1000, 64'hFFFFFFFF_FFFE7960);
      wait_out();
      hif.in_valid = 1'b1;
      hif.a        = 32'd2;
      hif.b        = 32'd2;
      exp_q.push_back(64'd4);
      repeat (10) begin
         @(posedge clk); #1;
      end
      hif.out_ready = 1'b1;
      @(posedge clk); #1;
      hif.out_ready = 1'b0;
      @(posedge clk); #1;
      hif.in_valid = 1'b0;
      hif.a        = $urandom;
      hif.b        = $urandom;
      take(0);

      // Reset in the middle of SHIFT (cnt = 20): the operation is dropped
      send(32'h00012345, 32'h00000777, 64'h0);
      repeat (21) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      #1;
      chk("async_out_valid", 64'(hif.out_valid), 64'd0);
      chk("async_busy",      64'(busy), 64'd0);
      chk("async_mrst",      64'(mrst), 64'd1);
      chk("async_in_ready",  64'(hif.in_ready), 64'd1);
      chk("async_prod",      hif.prod, 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      run(32'd6, 32'd7, 64'd42, 0);

      repeat (5) @(posedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
      $fatal(1, "time limit");
   end

endmodule
